// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory peripheral.
//   state_t        : transaction FSM states
//   OP_READ/WRITE  : values of the op bit in the command byte
//   CMD_*          : bit positions of the command byte fields {op, x, addr}
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int CMD_OP_BIT   = 7;
    localparam int CMD_ADDR_LSB = 0;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with edge detection for one asynchronous pin.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   din       : asynchronous input pin
//   sync_out  : synchronized level (2 flops after the pin)
//   rise/fall : one-cycle pulses on synchronized level changes
// RESET_VAL sets the idle level the chain assumes during reset.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI (mode 0) peripheral bridging a controller to a byte-wide memory.
// The first byte is a command {op, x, addr}; op=1 writes the following
// bytes to consecutive addresses, op=0 streams consecutive bytes back on
// miso. Addresses wrap at MEMORY_SIZE_IN_BYTES.
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   sclk, cs_n, mosi     : asynchronous SPI pins from the controller
//   miso, miso_oe        : serial read data and its drive enable
//   address, data_out    : memory address and write data
//   data_in              : memory read data, valid the cycle after rd
//   rd, wr               : one-cycle memory strobes
//   active               : high while a transaction is selected
//   done                 : (SPI_PERIPHERAL_DONE_EN only) one-cycle pulse at
//                          deselect when at least one data byte completed
//   state_dbg            : current FSM state for observation
// Optional feature macro: SPI_PERIPHERAL_DONE_EN.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int MEMORY_SIZE_IN_BYTES = 64,
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    output logic [AW-1:0] address,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out,
    output logic          rd,
    output logic          wr,
    output logic          active,
`ifdef SPI_PERIPHERAL_DONE_EN
    output logic          done,
`endif
    output logic [1:0]    state_dbg
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs_n),
        .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .sync_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          load_q, load_d;
    logic          miso_q, miso_d;
    logic          miso_oe_q, miso_oe_d;
    logic          active_q, active_d;
    logic [1:0]    settle_q, settle_d;
    logic          armed_q, armed_d;
    logic [7:0]    rx_byte;
    logic          byte_end;

    // Memory strobes: rd and wr are single-cycle pulses with no back-pressure.
    // address (and data_out for wr) is valid in the same cycle as the strobe;
    // read data is expected on data_in in the cycle after rd.

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        data_out_d = data_out_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        load_d     = rd_q;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        active_d   = active_q;
        // The cs_n chain resets to "deselected", so a controller already
        // holding cs_n low would look like a falling edge right after reset.
        // Only accept a start once the settled pin has been seen high.
        settle_d   = settle_q[1] ? settle_q : settle_q + 2'd1;
        armed_d    = armed_q | (settle_q[1] & cs_s);
        rx_byte    = {rx_q, mosi_s};
        byte_end   = sclk_rise && (bit_cnt_q == 3'd0);

        if (load_q) begin
            tx_d = data_in;
        end
        // Write address advances only after wr has presented it.
        if (wr_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d    = 1'b0;
                miso_oe_d = 1'b0;
                active_d  = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd7;
                    miso_oe_d = 1'b1;
                    active_d  = 1'b1;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (byte_end) begin
                        addr_d = rx_byte[CMD_ADDR_LSB +: AW];
                        if (rx_byte[CMD_OP_BIT] == OP_WRITE) begin
                            state_d = ST_WRITE;
                        end
                        if (rx_byte[CMD_OP_BIT] == OP_READ) begin
                            state_d = ST_READ;
                            rd_d    = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (sclk_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (byte_end) begin
                        data_out_d = rx_byte;
                        wr_d       = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    // Prefetch: the next byte is loaded long before the
                    // following falling edge since sclk is at most clk/8.
                    if (byte_end) begin
                        addr_d = addr_q + 1'b1;
                        rd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Deselect aborts from any state; an unfinished byte is dropped.
        if (cs_s && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            active_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            data_out_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            load_q     <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            active_q   <= 1'b0;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            load_q     <= load_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
            active_q   <= active_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

`ifdef SPI_PERIPHERAL_DONE_EN
    logic data_byte_done;
    logic seen_q, seen_d;
    logic done_q, done_d;

    always_comb begin
        data_byte_done = byte_end && ((state_q == ST_WRITE) || (state_q == ST_READ));
        seen_d         = seen_q | data_byte_done;
        done_d         = 1'b0;
        if (cs_s && (state_q != ST_IDLE)) begin
            done_d = seen_q | data_byte_done;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{sclk_s, cs_rise, mosi_rise, mosi_fall, rx_byte};

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign address   = addr_q;
    assign data_out  = data_out_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign active    = active_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: a behavioural SPI controller,
// a byte memory answering rd/wr, and a reference model of expected writes
// and read-back bytes derived from the command/address rules.
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int MEM = 64;
    localparam int AW  = $clog2(MEM);

    logic          clk;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic [AW-1:0] address;
    logic [7:0]    data_in = 8'h00;
    logic [7:0]    data_out;
    logic          rd;
    logic          wr;
    logic          active;
    logic [1:0]    state_dbg;
`ifdef SPI_PERIPHERAL_DONE_EN
    logic          done;
`endif

    spi_peripheral #(.MEMORY_SIZE_IN_BYTES(MEM)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .address(address), .data_in(data_in),
        .data_out(data_out), .rd(rd), .wr(wr), .active(active),
`ifdef SPI_PERIPHERAL_DONE_EN
        .done(done),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    int            half_clks = 4;
    int            rd_cnt = 0;
    int            overlap_cnt = 0;
    int            done_cnt = 0;
    logic [7:0]    mem [MEM];
    logic [7:0]    ref_mem [MEM];
    logic [7:0]    tx_buf [32];
    logic [7:0]    rx_buf [32];
    logic [AW+7:0] exp_q [$];
    logic [AW+7:0] obs_wr [$];

    // Memory and strobe observer.
    always @(negedge clk) begin
        if (wr) begin
            obs_wr.push_back({address, data_out});
            mem[address] = data_out;
        end
        if (rd) begin
            rd_cnt++;
            data_in = mem[address];
        end
        if (rd && wr) overlap_cnt++;
`ifdef SPI_PERIPHERAL_DONE_EN
        if (done) done_cnt++;
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        obs_wr.delete();
        exp_q.delete();
        rd_cnt = 0;
        overlap_cnt = 0;
    endtask

    task automatic set_mem(input int a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        repeat (half_clks) @(negedge clk);
        r = miso;
        sclk = 1'b1;
        repeat (half_clks) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_start();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (half_clks) @(negedge clk);
    endtask

    task automatic spi_bytes(input int first, input int n_full, input int extra_bits);
        logic r;
        for (int b = first; b < first + n_full; b++) begin
            for (int i = 7; i >= 0; i--) begin
                spi_bit(tx_buf[b][i], r);
                rx_buf[b][i] = r;
            end
        end
        for (int i = 7; i > 7 - extra_bits; i--) begin
            spi_bit(tx_buf[first + n_full][i], r);
        end
    endtask

    task automatic spi_end();
        repeat (half_clks) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_txn(input int n_full, input int extra_bits);
        spi_start();
        spi_bytes(0, n_full, extra_bits);
        spi_end();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL reset_miso: got %b want 0", miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        n_cmp++; if (address !== '0) begin n_err++; $display("FAIL reset_address: got %h want 0", address); end
        n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        n_cmp++; if (rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", rd); end
        n_cmp++; if (wr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", wr); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
`ifdef SPI_PERIPHERAL_DONE_EN
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
`endif
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write_basic();
        clear_obs();
        tx_buf[0] = 8'h85;
        tx_buf[1] = 8'hA5;
        tx_buf[2] = 8'h3C;
        exp_q.push_back({AW'(5), 8'hA5});
        exp_q.push_back({AW'(6), 8'h3C});
        spi_start();
        n_cmp++; if (active !== 1'b1) begin n_err++; $display("FAIL wb_active: got %b want 1", active); end
        n_cmp++; if (miso_oe !== 1'b1) begin n_err++; $display("FAIL wb_miso_oe: got %b want 1", miso_oe); end
        spi_bytes(0, 3, 0);
        spi_end();
        n_cmp++; if (obs_wr.size() !== exp_q.size()) begin n_err++; $display("FAIL wb_wr_count: got %0d want %0d", obs_wr.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_wr.size(); i++) begin
            n_cmp++; if (obs_wr[i] !== exp_q[i]) begin n_err++; $display("FAIL wb_wr[%0d]: got addr/data %h want %h", i, obs_wr[i], exp_q[i]); end
        end
        n_cmp++; if (rd_cnt !== 0) begin n_err++; $display("FAIL wb_rd_count: got %0d want 0", rd_cnt); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL wb_active_after: got %b want 0", active); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL wb_miso_oe_after: got %b want 0", miso_oe); end
    endtask

    task automatic test_read_wrap();
        clear_obs();
        set_mem(62, 8'h11);
        set_mem(63, 8'h22);
        set_mem(0, 8'h33);
        tx_buf[0] = 8'h3E;
        for (int i = 1; i < 4; i++) tx_buf[i] = 8'($urandom);
        spi_txn(4, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_buf[i+1] !== ref_mem[(62 + i) % MEM]) begin
                n_err++; $display("FAIL rd_wrap_byte[%0d]: got %h want %h", i, rx_buf[i+1], ref_mem[(62 + i) % MEM]);
            end
        end
        // One fetch for the first byte plus one prefetch after every byte.
        n_cmp++; if (rd_cnt !== 4) begin n_err++; $display("FAIL rd_wrap_rd_count: got %0d want 4", rd_cnt); end
        n_cmp++; if (obs_wr.size() !== 0) begin n_err++; $display("FAIL rd_wrap_no_wr: got %0d want 0", obs_wr.size()); end
    endtask

    task automatic test_partial();
        clear_obs();
        tx_buf[0] = 8'h81;
        tx_buf[1] = 8'($urandom);
        tx_buf[2] = 8'($urandom);
        exp_q.push_back({AW'(1), tx_buf[1]});
        spi_txn(2, 5);
        n_cmp++; if (obs_wr.size() !== 1) begin n_err++; $display("FAIL partial_wr_count: got %0d want 1", obs_wr.size()); end
        if (obs_wr.size() > 0) begin
            n_cmp++; if (obs_wr[0] !== exp_q[0]) begin n_err++; $display("FAIL partial_wr0: got %h want %h", obs_wr[0], exp_q[0]); end
        end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL partial_state: got %0d want %0d", state_dbg, ST_IDLE); end
        n_cmp++; if (address !== AW'(2)) begin n_err++; $display("FAIL partial_address: got %h want 2", address); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        for (int i = 16; i < 20; i++) set_mem(i, 8'($urandom));
        tx_buf[0] = 8'h10;
        tx_buf[1] = 8'h00;
        tx_buf[2] = 8'h00;
        spi_start();
        spi_bytes(0, 2, 0);
        spi_bytes(2, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (miso !== 1'b0) begin n_err++; $display("FAIL rmid_miso: got %b want 0", miso); end
        n_cmp++; if (miso_oe !== 1'b0) begin n_err++; $display("FAIL rmid_miso_oe: got %b want 0", miso_oe); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rmid_active: got %b want 0", active); end
        n_cmp++; if (address !== '0) begin n_err++; $display("FAIL rmid_address: got %h want 0", address); end
        n_cmp++; if (rd !== 1'b0) begin n_err++; $display("FAIL rmid_rd: got %b want 0", rd); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want %0d", state_dbg, ST_IDLE); end
        rst = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_wr.size() !== 0) begin n_err++; $display("FAIL rmid_no_wr: got %0d want 0", obs_wr.size()); end
        clear_obs();
        tx_buf[0] = 8'h80;
        tx_buf[1] = 8'h77;
        exp_q.push_back({AW'(0), 8'h77});
        spi_txn(2, 0);
        n_cmp++; if (obs_wr.size() !== 1) begin n_err++; $display("FAIL rmid_after_count: got %0d want 1", obs_wr.size()); end
        if (obs_wr.size() > 0) begin
            n_cmp++; if (obs_wr[0] !== exp_q[0]) begin n_err++; $display("FAIL rmid_after_wr: got %h want %h", obs_wr[0], exp_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        half_clks = 4;
        tx_buf[0] = 8'h80;
        for (int i = 0; i < 16; i++) begin
            tx_buf[i+1] = 8'($urandom);
            exp_q.push_back({AW'(i), tx_buf[i+1]});
            ref_mem[i] = tx_buf[i+1];
        end
        spi_txn(17, 0);
        n_cmp++; if (obs_wr.size() !== 16) begin n_err++; $display("FAIL b2b_count: got %0d want 16", obs_wr.size()); end
        for (int i = 0; i < 16 && i < obs_wr.size(); i++) begin
            n_cmp++; if (obs_wr[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_wr[%0d]: got %h want %h", i, obs_wr[i], exp_q[i]); end
        end
        n_cmp++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL b2b_rd_wr_overlap: got %0d want 0", overlap_cnt); end
    endtask

    task automatic test_random_rw();
        int start;
        int n;
        for (int it = 0; it < 4; it++) begin
            start = (it == 0) ? 60 : int'($urandom_range(0, MEM - 1));
            n = $urandom_range(1, 5);
            half_clks = $urandom_range(4, 6);
            clear_obs();
            tx_buf[0] = 8'(8'h80 | (8'($urandom_range(0, 1)) << 6) | 8'(start));
            for (int i = 0; i < n; i++) begin
                tx_buf[i+1] = 8'($urandom);
                exp_q.push_back({AW'((start + i) % MEM), tx_buf[i+1]});
                ref_mem[(start + i) % MEM] = tx_buf[i+1];
            end
            spi_txn(n + 1, 0);
            n_cmp++; if (obs_wr.size() !== n) begin n_err++; $display("FAIL rnd_wr_count[%0d]: got %0d want %0d", it, obs_wr.size(), n); end
            for (int i = 0; i < n && i < obs_wr.size(); i++) begin
                n_cmp++; if (obs_wr[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_wr[%0d.%0d]: got %h want %h", it, i, obs_wr[i], exp_q[i]); end
            end
            clear_obs();
            tx_buf[0] = 8'((8'($urandom_range(0, 1)) << 6) | 8'(start));
            for (int i = 0; i < n; i++) tx_buf[i+1] = 8'($urandom);
            spi_txn(n + 1, 0);
            for (int i = 0; i < n; i++) begin
                n_cmp++;
                if (rx_buf[i+1] !== ref_mem[(start + i) % MEM]) begin
                    n_err++; $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", it, i, rx_buf[i+1], ref_mem[(start + i) % MEM]);
                end
            end
            n_cmp++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL rnd_overlap[%0d]: got %0d want 0", it, overlap_cnt); end
        end
        half_clks = 4;
    endtask

`ifdef SPI_PERIPHERAL_DONE_EN
    task automatic test_done();
        done_cnt = 0;
        tx_buf[0] = 8'h80;
        spi_txn(1, 0);
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL done_cmd_only: got %0d want 0", done_cnt); end
        done_cnt = 0;
        tx_buf[0] = 8'h82;
        tx_buf[1] = 8'h11;
        tx_buf[2] = 8'h22;
        spi_txn(1, 5);
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL done_partial: got %0d want 0", done_cnt); end
        done_cnt = 0;
        tx_buf[0] = 8'h81;
        tx_buf[1] = 8'h5A;
        spi_txn(2, 0);
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL done_one_byte: got %0d want 1", done_cnt); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        for (int i = 0; i < MEM; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        test_reset();
        test_write_basic();
        test_read_wrap();
        test_partial();
        test_reset_mid();
        test_back_to_back();
        test_random_rw();
`ifdef SPI_PERIPHERAL_DONE_EN
        test_done();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
